// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse train generator.
package pulse_gen_pkg;

  localparam int DEFAULT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_cnt.sv
// Loadable down-counter used for both phase timing and pulse counting.
// It stops at 1 instead of wrapping so the owner always reloads it.
module pulse_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] value;

  // Load has priority over decrement; decrement never goes below 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && !last) begin
      value <= value - 1'b1;
    end
  end

  assign last = (value == W'(1));

endmodule

// File: rtl/pulse_train_generator.sv
// Generates a train of count pulses, each width cycles high and separated by
// gap low cycles. Zero width/gap are treated as one cycle.
module pulse_train_generator
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] count,
  output logic             a,
  output logic             busy,
  output logic             done
);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] eff_width;
  logic [CNT_W-1:0] eff_gap;

  logic             latch_en;
  logic             a_next;
  logic             busy_next;
  logic             done_next;

  logic             ph_load;
  logic [CNT_W-1:0] ph_value;
  logic             ph_dec;
  logic             ph_last;

  logic             pc_load;
  logic             pc_dec;
  logic             pc_last;

  assign eff_width = (width == '0) ? CNT_W'(1) : width;
  assign eff_gap   = (gap == '0)   ? CNT_W'(1) : gap;

  // Phase counter: times the current high or low stretch.
  pulse_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (ph_load),
    .load_value (ph_value),
    .dec        (ph_dec),
    .last       (ph_last)
  );

  // Pulse counter: counts pulses remaining, including the current one.
  pulse_cnt #(.W(CNT_W)) u_pulse_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .load_value (count),
    .dec        (pc_dec),
    .last       (pc_last)
  );

  // Next-state, counter control and next output values.
  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    a_next     = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    ph_load    = 1'b0;
    ph_value   = width_q;
    ph_dec     = 1'b0;
    pc_load    = 1'b0;
    pc_dec     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          if (count == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = PULSE;
            ph_load    = 1'b1;
            ph_value   = eff_width;
            pc_load    = 1'b1;
            a_next     = 1'b1;
            busy_next  = 1'b1;
          end
        end
      end
      PULSE: begin
        if (ph_last) begin
          if (pc_last) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = GAP;
            ph_load    = 1'b1;
            ph_value   = gap_q;
            pc_dec     = 1'b1;
            busy_next  = 1'b1;
          end
        end else begin
          ph_dec    = 1'b1;
          a_next    = 1'b1;
          busy_next = 1'b1;
        end
      end
      GAP: begin
        busy_next = 1'b1;
        if (ph_last) begin
          state_next = PULSE;
          ph_load    = 1'b1;
          ph_value   = width_q;
          a_next     = 1'b1;
        end else begin
          ph_dec = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      a     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      a     <= a_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Effective width and gap captured when a start is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width_q <= '0;
      gap_q   <= '0;
    end else if (latch_en) begin
      width_q <= eff_width;
      gap_q   <= eff_gap;
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator with hand-computed traces.
module tb_pulse_train_generator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] width;
  logic [3:0] gap;
  logic [3:0] count;
  logic       a;
  logic       busy;
  logic       done;

  int total;
  int bad;

  logic [63:0] a_tr;
  logic [63:0] busy_tr;
  logic [63:0] done_tr;

  int pos_count;
  int one_count;
  int bad_run;
  int done_count;
  int done_at;

  pulse_train_generator #(.CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .width (width),
    .gap   (gap),
    .count (count),
    .a     (a),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts the start.
  task automatic applyStimulus(input logic [3:0] w, input logic [3:0] g,
                               input logic [3:0] c, input logic hold);
    width = w;
    gap   = g;
    count = c;
    start = 1'b1;
    @(posedge clk);
    #1 start = hold;
  endtask

  // Samples n cycles; the first sampled cycle lands in the MSB of the n-bit trace.
  task automatic capture(input int n);
    a_tr    = '0;
    busy_tr = '0;
    done_tr = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a_tr    = {a_tr[62:0], a};
      busy_tr = {busy_tr[62:0], busy};
      done_tr = {done_tr[62:0], done};
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Posedge / one-cycle-pulse detection plus run-length checking on a.
  task automatic runMonitor(input int n, input int exp_w, input int exp_g);
    logic prev;
    int   run;
    int   low;
    bit   seen_high;
    prev = 1'b0;
    run = 0;
    low = 0;
    seen_high = 1'b0;
    pos_count = 0;
    one_count = 0;
    bad_run = 0;
    done_count = 0;
    done_at = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (a) begin
        if (!prev) begin
          pos_count++;
          if (seen_high && low != exp_g) bad_run++;
          run = 0;
        end
        run++;
        seen_high = 1'b1;
      end else begin
        if (prev) begin
          if (run != exp_w) bad_run++;
          if (run == 1) one_count++;
          low = 0;
        end
        low++;
      end
      if (done) begin
        done_count++;
        done_at = k;
      end
      prev = a;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    start = 1'b0;
    width = '0;
    gap   = '0;
    count = '0;

    idle(2);
    checkOutput("reset_a",    {63'd0, a},    64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    rst = 1'b1;
    idle(2);
    checkOutput("idle_outs", {61'd0, a, busy, done}, 64'd0);

    // Basic train w=1 g=1 c=3
    applyStimulus(4'd1, 4'd1, 4'd3, 1'b0);
    capture(7);
    checkOutput("basic_a",    a_tr,    64'b1010100);
    checkOutput("basic_busy", busy_tr, 64'b1111100);
    checkOutput("basic_done", done_tr, 64'b0000010);
    idle(2);

    // Zero gap: w=2 g=0 c=2
    applyStimulus(4'd2, 4'd0, 4'd2, 1'b0);
    capture(7);
    checkOutput("zgap_a",    a_tr,    64'b1101100);
    checkOutput("zgap_busy", busy_tr, 64'b1111100);
    checkOutput("zgap_done", done_tr, 64'b0000010);
    idle(2);

    // Zero count
    applyStimulus(4'd3, 4'd3, 4'd0, 1'b0);
    capture(3);
    checkOutput("zcnt_a",    a_tr,    64'b000);
    checkOutput("zcnt_busy", busy_tr, 64'b000);
    checkOutput("zcnt_done", done_tr, 64'b100);
    idle(2);

    // Start held, fields changed mid-train; second train uses new fields
    applyStimulus(4'd3, 4'd2, 4'd2, 1'b1);
    width = 4'd1;
    gap   = 4'd1;
    count = 4'd5;
    capture(10);
    checkOutput("hold_a",    a_tr,    64'b1110011101);
    checkOutput("hold_busy", busy_tr, 64'b1111111101);
    checkOutput("hold_done", done_tr, 64'b0000000010);
    start = 1'b0;
    capture(10);
    checkOutput("hold2_a",    a_tr,    64'b0101010100);
    checkOutput("hold2_done", done_tr, 64'b0000000010);
    idle(2);

    // Back-to-back trains via start in the done cycle
    applyStimulus(4'd2, 4'd1, 4'd1, 1'b1);
    capture(6);
    checkOutput("b2b_a",    a_tr,    64'b110110);
    checkOutput("b2b_busy", busy_tr, 64'b110110);
    checkOutput("b2b_done", done_tr, 64'b001001);
    start = 1'b0;
    capture(3);
    checkOutput("b2b_tail_a", a_tr, 64'b000);
    idle(2);

    // Mid-train asynchronous reset
    applyStimulus(4'd4, 4'd1, 4'd3, 1'b0);
    capture(2);
    checkOutput("pre_rst_a", a_tr, 64'b11);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_outs", {61'd0, a, busy, done}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    runMonitor(8, 4, 1);
    checkOutput("post_rst_pulses", pos_count,  0);
    checkOutput("post_rst_done",   done_count, 0);

    // Maximum field values
    applyStimulus(4'd15, 4'd15, 4'd15, 1'b0);
    runMonitor(440, 15, 15);
    checkOutput("max_pulses",  pos_count,  15);
    checkOutput("max_runs",    bad_run,    0);
    checkOutput("max_done_n",  done_count, 1);
    checkOutput("max_done_at", done_at,    436);
    idle(2);

    // Detector loop, one-cycle pulses
    applyStimulus(4'd1, 4'd2, 4'd4, 1'b0);
    runMonitor(13, 1, 2);
    checkOutput("det1_pos",  pos_count,  4);
    checkOutput("det1_one",  one_count,  4);
    checkOutput("det1_runs", bad_run,    0);
    checkOutput("det1_done", done_at,    11);
    idle(2);

    // Detector loop, two-cycle pulses
    applyStimulus(4'd2, 4'd2, 4'd4, 1'b0);
    runMonitor(16, 2, 2);
    checkOutput("det2_pos",  pos_count, 4);
    checkOutput("det2_one",  one_count, 0);
    checkOutput("det2_runs", bad_run,   0);
    checkOutput("det2_done", done_at,   15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
